// File: rtl/ddr3_resp_pkg.sv
// ----------------------------------------------------------------------------
// ddr3_resp_pkg : command encodings, bank-state type and read-data pattern
//                 shared by the DDR3 command responder.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ddr3_resp_pkg;

    // {ras_n, cas_n, we_n}
    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_MRS = 3'b000;
    localparam logic [2:0] CMD_ZQ  = 3'b110;

    localparam logic [15:0] DATA_TAG = 16'hDA7A;
    localparam int unsigned NUM_BANKS = 8;

    typedef enum logic [1:0] {
        B_IDLE   = 2'd0,
        B_OPEN   = 2'd1,
        B_PRECHG = 2'd2
    } bank_state_e;

    function automatic logic [63:0] rd_word(input logic [13:0] row,
                                            input logic [2:0]  bank,
                                            input logic [9:0]  col);
        return {DATA_TAG, 2'b00, row, 13'b0, bank, 6'b0, col};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ddr3_bank_tracker.sv
// ----------------------------------------------------------------------------
// ddr3_bank_tracker : per-bank open/precharge FSM, open row and spacing checks.
// Spacing counter present only when DDR3_RESP_TIMING_CHECK_EN is defined.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ddr3_bank_tracker
    import ddr3_resp_pkg::*;
#(
    parameter int ROW_W    = 14,
    parameter int tRCD_CYC = 6,
    parameter int tRP_CYC  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_act,
    input  logic             i_rd,
    input  logic             i_pre,
    input  logic [ROW_W-1:0] i_row,
    output logic             o_open,
    output logic [ROW_W-1:0] o_row,
    output logic             o_err_rcd,
    output logic             o_err_rp,
    output logic             o_err_closed,
    output logic             o_err_act_open
);

    bank_state_e      r_state;
    logic [ROW_W-1:0] r_row;
    logic             w_is_open;

    assign w_is_open = (r_state == B_OPEN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
        end else if (i_act) begin
            r_row <= i_row;
        end
    end

`ifdef DDR3_RESP_TIMING_CHECK_EN
    localparam logic [7:0] c_RCD = 8'(tRCD_CYC);
    localparam logic [7:0] c_RP  = 8'(tRP_CYC);

    // Holds k at the edge k cycles after the last ACT/PRE, saturating.
    logic [7:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (i_act || (i_pre && w_is_open)) begin
            r_cnt <= 8'd1;
        end else if (r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= B_IDLE;
        end else begin
            case (r_state)
                B_IDLE:   if (i_act) r_state <= B_OPEN;
                B_OPEN:   if (!i_act && i_pre) r_state <= B_PRECHG;
                B_PRECHG: begin
                    if (i_act)              r_state <= B_OPEN;
                    else if (r_cnt >= c_RP) r_state <= B_IDLE;
                end
                default:  r_state <= B_IDLE;
            endcase
        end
    end

    assign o_err_rcd = i_rd && w_is_open && (r_cnt < c_RCD);
    assign o_err_rp  = i_act && (r_state == B_PRECHG) && (r_cnt < c_RP);
`else
    localparam int c_unused_spacing = tRCD_CYC + tRP_CYC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= B_IDLE;
        end else begin
            case (r_state)
                B_IDLE:  if (i_act) r_state <= B_OPEN;
                B_OPEN:  if (!i_act && i_pre) r_state <= B_IDLE;
                default: r_state <= B_IDLE;
            endcase
        end
    end

    assign o_err_rcd = 1'b0;
    assign o_err_rp  = 1'b0;
`endif

    assign o_open         = w_is_open;
    assign o_row          = r_row;
    assign o_err_closed   = i_rd && !w_is_open;
    assign o_err_act_open = i_act && w_is_open;

endmodule

`default_nettype wire

// File: rtl/ddr3_cmd_responder.sv
// ----------------------------------------------------------------------------
// ddr3_cmd_responder : DDR3 device-side command decoder with bank tracking,
// CL-delayed pattern read data, sticky error flags and command counters.
// Optional spacing checks: define DDR3_RESP_TIMING_CHECK_EN.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ddr3_cmd_responder
    import ddr3_resp_pkg::*;
#(
    parameter int ROW_W    = 14,
    parameter int COL_W    = 10,
    parameter int DATA_W   = 64,
    parameter int tRCD_CYC = 6,
    parameter int tRP_CYC  = 6,
    parameter int CL_CYC   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cke,
    input  logic              cs_n,
    input  logic              ras_n,
    input  logic              cas_n,
    input  logic              we_n,
    input  logic [2:0]        ba,
    input  logic [ROW_W-1:0]  addr,
    input  logic              odt,
    input  logic              err_clear,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [7:0]        bank_open,
    output logic              err_rcd,
    output logic              err_rp,
    output logic              err_closed,
    output logic              err_act_open,
    output logic              err_cmd,
    output logic [31:0]       act_seen,
    output logic [31:0]       rd_seen,
    output logic [31:0]       pre_seen
);

    logic        w_unused_odt;
    logic        w_cmd_en;
    logic [2:0]  w_cmd;
    logic        w_act, w_rd, w_pre, w_bad;
    logic        w_rd_push;
    logic [63:0] w_rd_word;

    logic [ROW_W-1:0] w_row [NUM_BANKS];
    logic [7:0]       w_open, w_e_rcd, w_e_rp, w_e_closed, w_e_act_open;

    assign w_unused_odt = odt;
    assign w_cmd_en     = cke && !cs_n;
    assign w_cmd        = {ras_n, cas_n, we_n};
    assign w_act        = w_cmd_en && (w_cmd == CMD_ACT);
    assign w_rd         = w_cmd_en && (w_cmd == CMD_RD);
    assign w_pre        = w_cmd_en && (w_cmd == CMD_PRE);
    assign w_bad        = w_cmd_en && ((w_cmd == CMD_WR)  || (w_cmd == CMD_REF) ||
                                       (w_cmd == CMD_MRS) || (w_cmd == CMD_ZQ));

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            ddr3_bank_tracker #(
                .ROW_W    (ROW_W),
                .tRCD_CYC (tRCD_CYC),
                .tRP_CYC  (tRP_CYC)
            ) u_bank (
                .clk            (clk),
                .rst            (rst),
                .i_act          (w_act && (ba == 3'(gi))),
                .i_rd           (w_rd && (ba == 3'(gi))),
                .i_pre          (w_pre && (addr[10] || (ba == 3'(gi)))),
                .i_row          (addr),
                .o_open         (w_open[gi]),
                .o_row          (w_row[gi]),
                .o_err_rcd      (w_e_rcd[gi]),
                .o_err_rp       (w_e_rp[gi]),
                .o_err_closed   (w_e_closed[gi]),
                .o_err_act_open (w_e_act_open[gi])
            );
        end
    endgenerate

    // Reads to a closed bank return nothing; early reads still return data.
    assign w_rd_push = w_rd && w_open[ba];
    assign w_rd_word = rd_word(14'(w_row[ba]), ba, 10'(addr[COL_W-1:0]));

    logic              r_pipe_vld [CL_CYC];
    logic [63:0]       r_pipe_dat [CL_CYC];
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CL_CYC; i++) begin
                r_pipe_vld[i] <= 1'b0;
                r_pipe_dat[i] <= 64'd0;
            end
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_pipe_vld[0] <= w_rd_push;
            r_pipe_dat[0] <= w_rd_push ? w_rd_word : 64'd0;
            for (int i = 1; i < CL_CYC; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_dat[i] <= r_pipe_dat[i-1];
            end
            r_rd_valid <= r_pipe_vld[CL_CYC-1];
            r_rd_data  <= DATA_W'(r_pipe_dat[CL_CYC-1]);
        end
    end

    logic        r_err_rcd, r_err_rp, r_err_closed, r_err_act_open, r_err_cmd;
    logic [31:0] r_act_seen, r_rd_seen, r_pre_seen;

    // A fresh error in the clearing cycle keeps its flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_rcd      <= 1'b0;
            r_err_rp       <= 1'b0;
            r_err_closed   <= 1'b0;
            r_err_act_open <= 1'b0;
            r_err_cmd      <= 1'b0;
        end else begin
            r_err_rcd      <= (r_err_rcd      && !err_clear) || (|w_e_rcd);
            r_err_rp       <= (r_err_rp       && !err_clear) || (|w_e_rp);
            r_err_closed   <= (r_err_closed   && !err_clear) || (|w_e_closed);
            r_err_act_open <= (r_err_act_open && !err_clear) || (|w_e_act_open);
            r_err_cmd      <= (r_err_cmd      && !err_clear) || w_bad;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act_seen <= 32'd0;
            r_rd_seen  <= 32'd0;
            r_pre_seen <= 32'd0;
        end else begin
            if (w_act) r_act_seen <= r_act_seen + 32'd1;
            if (w_rd)  r_rd_seen  <= r_rd_seen  + 32'd1;
            if (w_pre) r_pre_seen <= r_pre_seen + 32'd1;
        end
    end

    assign rd_valid     = r_rd_valid;
    assign rd_data      = r_rd_data;
    assign bank_open    = w_open;
    assign err_rcd      = r_err_rcd;
    assign err_rp       = r_err_rp;
    assign err_closed   = r_err_closed;
    assign err_act_open = r_err_act_open;
    assign err_cmd      = r_err_cmd;
    assign act_seen     = r_act_seen;
    assign rd_seen      = r_rd_seen;
    assign pre_seen     = r_pre_seen;

endmodule

`default_nettype wire

// File: tb/tb_ddr3_cmd_responder.sv
// ----------------------------------------------------------------------------
// tb_ddr3_cmd_responder : directed bench for ddr3_cmd_responder with a
// read-data scoreboard keyed on expected strobe cycle.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ddr3_cmd_responder;

    localparam int ROW_W = 14;
    localparam int COL_W = 10;
    localparam int DATA_W = 64;
    localparam int TRCD = 6;
    localparam int TRP = 6;
    localparam int CL = 6;
`ifdef DDR3_RESP_TIMING_CHECK_EN
    localparam logic TCHK = 1'b1;
`else
    localparam logic TCHK = 1'b0;
`endif

    localparam logic [2:0] NOP = 3'b111;
    localparam logic [2:0] ACT = 3'b011;
    localparam logic [2:0] RD  = 3'b101;
    localparam logic [2:0] PRE = 3'b010;
    localparam logic [2:0] WR  = 3'b100;
    localparam logic [2:0] REF = 3'b001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cke = 1'b0, cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [2:0] ba = 3'd0;
    logic [ROW_W-1:0] addr = '0;
    logic odt = 1'b0, err_clear = 1'b0;
    logic rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [7:0] bank_open;
    logic err_rcd, err_rp, err_closed, err_act_open, err_cmd;
    logic [31:0] act_seen, rd_seen, pre_seen;

    ddr3_cmd_responder #(
        .ROW_W(ROW_W), .COL_W(COL_W), .DATA_W(DATA_W),
        .tRCD_CYC(TRCD), .tRP_CYC(TRP), .CL_CYC(CL)
    ) dut (
        .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n),
        .cas_n(cas_n), .we_n(we_n), .ba(ba), .addr(addr), .odt(odt),
        .err_clear(err_clear), .rd_valid(rd_valid), .rd_data(rd_data),
        .bank_open(bank_open), .err_rcd(err_rcd), .err_rp(err_rp),
        .err_closed(err_closed), .err_act_open(err_act_open), .err_cmd(err_cmd),
        .act_seen(act_seen), .rd_seen(rd_seen), .pre_seen(pre_seen)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [63:0] data;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          n_asserts = 0;
    int          n_fail = 0;
    logic        m_open [8];
    logic [13:0] m_row [8];
    logic [31:0] e_act = 0, e_rd = 0, e_pre = 0;

    always @(posedge clk) cyc++;

    function automatic logic [63:0] exp_word(input logic [13:0] row,
                                             input logic [2:0] b,
                                             input logic [9:0] col);
        return {16'hDA7A, 2'b00, row, 13'b0, b, 6'b0, col};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [4:0] errs();
        return {err_rcd, err_rp, err_closed, err_act_open, err_cmd};
    endfunction

    task automatic cmd(input logic [2:0] rcw, input logic [2:0] b, input logic [13:0] a);
        exp_t e;
        cke = 1'b1; cs_n = 1'b0; {ras_n, cas_n, we_n} = rcw; ba = b; addr = a;
        case (rcw)
            ACT: begin e_act++; m_open[b] = 1'b1; m_row[b] = a; end
            RD: begin
                e_rd++;
                if (m_open[b]) begin
                    e.cyc  = cyc + 1 + CL;
                    e.data = exp_word(m_row[b], b, a[9:0]);
                    q.push_back(e);
                end
            end
            PRE: begin
                e_pre++;
                if (a[10]) begin
                    for (int i = 0; i < 8; i++) m_open[i] = 1'b0;
                end else begin
                    m_open[b] = 1'b0;
                end
            end
            default: ;
        endcase
        @(negedge clk);
        cs_n = 1'b1; {ras_n, cas_n, we_n} = NOP;
    endtask

    task automatic nops(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_errs();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
    endtask

    // Read-data monitor: every strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_valid) begin
                if (q.size() == 0) begin
                    check("rd_unexpected", {63'd0, rd_valid}, 64'd0);
                end else begin
                    check("rd_cycle", 64'(cyc), 64'(q[0].cyc));
                    check("rd_data", rd_data, q[0].data);
                    void'(q.pop_front());
                end
            end else if (q.size() != 0 && cyc >= q[0].cyc) begin
                check("rd_missing", 64'(cyc), 64'(q[0].cyc + 1000));
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin m_open[i] = 1'b0; m_row[i] = '0; end
        nops(3);
        check("reset_bank_open", 64'(bank_open), 64'd0);
        check("reset_errs", 64'(errs()), 64'd0);
        check("reset_rd_valid", 64'(rd_valid), 64'd0);
        check("reset_counters", {act_seen, rd_seen | pre_seen}, 64'd0);
        rst = 1'b0;
        nops(2);

        // Basic read: ACT b2, RD 8 cycles later
        cmd(ACT, 3'd2, 14'h0123);
        check("act_b2_open", 64'(bank_open), 64'h04);
        nops(7);
        cmd(RD, 3'd2, 14'h0045);
        nops(9);
        check("basic_errs", 64'(errs()), 64'd0);
        check("basic_act_seen", 64'(act_seen), 64'(e_act));
        check("basic_rd_seen", 64'(rd_seen), 64'(e_rd));

        // Early read: data still returned
        cmd(ACT, 3'd1, 14'h03AB);
        nops(2);
        cmd(RD, 3'd1, 14'h03FF);
        check("rcd_errs", 64'(errs()), 64'({TCHK, 4'b0000}));
        nops(8);
        clear_errs();
        check("rcd_cleared", 64'(errs()), 64'd0);

        // Read to a closed bank
        cmd(RD, 3'd5, 14'h0001);
        check("closed_errs", 64'(errs()), 64'b00100);
        nops(8);
        clear_errs();
        check("closed_cleared", 64'(errs()), 64'd0);

        // Precharge spacing and ACT-while-open
        cmd(ACT, 3'd3, 14'h0007);
        nops(6);
        cmd(PRE, 3'd3, 14'h0000);
        check("pre_b3_open", 64'(bank_open), 64'h06);
        nops(1);
        cmd(ACT, 3'd3, 14'h0008);
        check("rp_errs", 64'(errs()), 64'({1'b0, TCHK, 3'b000}));
        cmd(ACT, 3'd3, 14'h0009);
        check("act_open_errs", 64'(errs()), 64'({1'b0, TCHK, 3'b010}));
        clear_errs();
        cmd(PRE, 3'd3, 14'h0000);
        nops(5);
        cmd(ACT, 3'd3, 14'h00AB);
        check("rp_boundary_errs", 64'(errs()), 64'd0);
        nops(5);
        cmd(RD, 3'd3, 14'h0012);
        check("rcd_boundary_errs", 64'(errs()), 64'd0);
        nops(8);

        // Illegal commands, clear-vs-set priority, deselect
        cmd(WR, 3'd2, 14'h0000);
        check("wr_err_cmd", 64'(errs()), 64'b00001);
        check("wr_no_state", 64'(bank_open), 64'h0E);
        err_clear = 1'b1;
        cmd(REF, 3'd0, 14'h0000);
        err_clear = 1'b0;
        check("clear_vs_new", 64'(err_cmd), 64'd1);
        clear_errs();
        check("cmd_cleared", 64'(errs()), 64'd0);
        cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = ACT; ba = 3'd7;
        @(negedge clk);
        cke = 1'b0; cs_n = 1'b0;
        @(negedge clk);
        cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = NOP;
        check("deselect_open", 64'(bank_open), 64'h0E);
        check("deselect_act_seen", 64'(act_seen), 64'(e_act));

        // Precharge-all
        cmd(ACT, 3'd0, 14'h0001);
        cmd(ACT, 3'd4, 14'h0002);
        check("two_more_open", 64'(bank_open), 64'h1F);
        cmd(PRE, 3'd0, 14'h0400);
        check("pre_all_open", 64'(bank_open), 64'h00);
        check("pre_all_seen", 64'(pre_seen), 64'(e_pre));

        // Back-to-back reads
        cmd(ACT, 3'd6, 14'h02AA);
        nops(5);
        for (int i = 0; i < 4; i++) cmd(RD, 3'd6, 14'(10 + i));
        nops(10);
        check("b2b_rd_seen", 64'(rd_seen), 64'(e_rd));
        check("b2b_errs", 64'(errs()), 64'd0);

        // Reset with reads in flight
        cmd(RD, 3'd6, 14'h0020);
        cmd(RD, 3'd6, 14'h0021);
        rst = 1'b1;
        q.delete();
        for (int i = 0; i < 8; i++) m_open[i] = 1'b0;
        e_act = 0; e_rd = 0; e_pre = 0;
        nops(2);
        rst = 1'b0;
        nops(12);
        check("post_rst_counters", {act_seen, rd_seen}, 64'd0);
        check("post_rst_pre_seen", 64'(pre_seen), 64'd0);
        check("post_rst_open", 64'(bank_open), 64'd0);
        check("post_rst_errs", 64'(errs()), 64'd0);
        check("queue_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
